uart_phy: RTL

Serial 8N1 UART that serves the CPU side of the UART I/O port (`uart0_wr`, `uart_w`, `uart0_rd`, `uart0_valid`, `uart0_data`). It accepts bytes from the I/O write strobe into a TX FIFO and shifts them out on `uart_tx`. It deserialises `uart_rx` into an RX FIFO whose head is presented for I/O reads. The block sits beside the j1 core top level and connects to the board UART pins.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_phy_if.sv | 23 ++
 rtl/uart_fifo.sv | 43 ++++
 rtl/uart_phy.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encodings for the 8N1 UART PHY.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 417;  // 48 MHz / 115200
    localparam int FIFO_AW_DEFAULT  = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd3,
        RX_WAITHI = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_phy_if.sv
// CPU-side I/O port of the UART PHY.
// uart0_wr/uart0_rd are single-cycle strobes with no ready: a write while tx_full is
// dropped, a read while !uart0_valid is ignored; uart0_data is show-ahead while uart0_valid.
interface uart_phy_if;
    import uart_pkg::*;

    logic                 uart0_wr;
    logic [DATA_BITS-1:0] uart_w;
    logic                 uart0_rd;
    logic                 uart0_valid;
    logic [DATA_BITS-1:0] uart0_data;
    logic                 tx_full;

    modport master (
        output uart0_wr, uart_w, uart0_rd,
        input  uart0_valid, uart0_data, tx_full
    );

    modport slave (
        input  uart0_wr, uart_w, uart0_rd,
        output uart0_valid, uart0_data, tx_full
    );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous show-ahead byte FIFO; a pop on a full FIFO frees room for a same-cycle push.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int AW = FIFO_AW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetq,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full
);

    logic [DATA_BITS-1:0] mem [0:(1 << AW)-1];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART PHY: TX FIFO + serialiser, synchronised RX deserialiser + RX FIFO.
module uart_phy
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int FIFO_AW  = FIFO_AW_DEFAULT
) (
    input  logic       clk,
    input  logic       resetq,
    uart_phy_if.slave  cpu,
    output logic       rx_overrun,
    output logic       rx_ferr,
    output logic       uart_tx,
    input  logic       uart_rx,
    output tx_state_t  tx_state_dbg,
    output rx_state_t  rx_state_dbg
);

    localparam int             CW        = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0]  BAUD_FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0]  BAUD_HALF = CW'(BAUD_DIV / 2);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_bit_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] tx_dout;
    logic                 tx_empty, tx_pop, tx_line, tx_bit_end;

    uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .resetq(resetq),
        .push(cpu.uart0_wr), .pop(tx_pop), .din(cpu.uart_w),
        .dout(tx_dout), .empty(tx_empty), .full(cpu.tx_full)
    );

    assign tx_bit_end   = (tx_cnt == CW'(1));
    assign tx_state_dbg = tx_state;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) tx_state <= TX_IDLE;
        else         tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_next = TX_START;
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit_idx == LAST_BIT) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop  = (tx_state == TX_IDLE) && !tx_empty;
        tx_line = 1'b1;
        unique case (tx_state)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_shift[0];
            default:  tx_line = 1'b1;
        endcase
    end

    // Counter reloads on every bit boundary; the shift register advances only between data bits.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            uart_tx    <= 1'b1;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
        end else begin
            uart_tx <= tx_line;
            if (tx_pop) begin
                tx_shift   <= tx_dout;
                tx_cnt     <= BAUD_FULL;
                tx_bit_idx <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= BAUD_FULL;
                    if (tx_state == TX_DATA) begin
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_idx <= tx_bit_idx + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 1'b1;
                end
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t            rx_state, rx_next;
    logic                 rx_s1, rx_s2, rx_sync;
    logic [1:0]           rx_settle;
    logic                 rx_armed;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_bit_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_sample, rx_push, rx_bad_stop, rx_empty, rx_full;

    uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .resetq(resetq),
        .push(rx_push), .pop(cpu.uart0_rd), .din(rx_shift),
        .dout(cpu.uart0_data), .empty(rx_empty), .full(rx_full)
    );

    assign rx_sync          = rx_s2;
    assign rx_sample        = (rx_cnt == CW'(1));
    assign cpu.uart0_valid  = !rx_empty;
    assign rx_state_dbg     = rx_state;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:   if (rx_armed && !rx_sync) rx_next = RX_START;
            RX_START:  if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit_idx == LAST_BIT) rx_next = RX_STOP;
            RX_STOP:   if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_WAITHI;
            RX_WAITHI: if (rx_sync) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push     = (rx_state == RX_STOP) && rx_sample && rx_sync;
        rx_bad_stop = (rx_state == RX_STOP) && rx_sample && !rx_sync;
    end

    // rx_armed needs a genuine high on the line after reset, so a frame cut by reset is not re-entered.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_settle  <= '0;
            rx_armed   <= 1'b0;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
            rx_overrun <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_settle  <= {rx_settle[0], 1'b1};
            if (rx_settle[1] && rx_sync) rx_armed <= 1'b1;
            rx_overrun <= rx_push && rx_full && !cpu.uart0_rd;
            rx_ferr    <= rx_bad_stop;
            if (rx_state == RX_IDLE || rx_state == RX_WAITHI) begin
                rx_cnt     <= BAUD_HALF;
                rx_bit_idx <= '0;
            end else if (rx_sample) begin
                rx_cnt <= BAUD_FULL;
                if (rx_state == RX_DATA) begin
                    rx_shift   <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                    rx_bit_idx <= rx_bit_idx + 1'b1;
                end
            end else begin
                rx_cnt <= rx_cnt - 1'b1;
            end
        end
    end

endmodule
